debouncer_array: RTL and testbench
==================================

// Module: debouncer_array
//
// PURPOSE
//   N-channel switch/button debouncer with a run-time programmable filter
//   length. Each channel has its own synchroniser and stability counter. Each
//   channel has a clean level output plus single-cycle rise and fall event
//   pulses. Sits between board-level GPIO/push-button pins and control logic;
//   replaces per-pin instances of the fixed single-channel debouncer.
//
// PARAMETERS
//   N       4     number of independent channels
//   CW      16    stability counter width; max filter length 2**CW-1 cycles
//   SYNCS   2     synchroniser depth in flops, >=2
//   RSTVAL  0     N-bit value of the synchroniser flops and clean_out after reset
//
// PORTS
//   clk        in   1    clock, all logic on rising edge
//   reset      in   1    synchronous, active-high reset
//   noisy_in   in   N    asynchronous raw inputs
//   thresh     in   CW   cycles an input must be stable before it is accepted;
//                        quasi-static; 0 is treated as 1
//   en         in   1    1 = filter runs; 0 = counters and outputs freeze
//   clean_out  out  N    debounced levels
//   rise       out  N    1-cycle pulse when clean_out[i] goes 0->1
//   fall       out  N    1-cycle pulse when clean_out[i] goes 1->0
//   any_event  out  1    OR of rise|fall (combinational from registered bits)
//
// BEHAVIOUR
//   Reset (sampled at clk edge while reset=1):
//   - synchroniser flops and clean_out load RSTVAL;
//   - all counters go to 0; rise and fall go to 0.
//   - Reset has priority over en.
//   - Reset mid-count discards any partial count. There are no event pulses
//     on reset exit, even if noisy_in differs from RSTVAL.
//   Per channel i, s[i] = last synchroniser stage:
//   - en=0: cnt[i] holds, clean_out[i] holds, rise[i]=fall[i]=0. The
//     synchroniser keeps running.
//   - en=1, s[i]==clean_out[i]: cnt[i] <= 0.
//   - en=1, s[i]!=clean_out[i], cnt[i] < T-1, where T = (thresh==0) ? 1 : thresh:
//     cnt[i] <= cnt[i]+1.
//   - en=1, s[i]!=clean_out[i], cnt[i] >= T-1: clean_out[i] <= s[i] and
//     cnt[i] <= 0. On that same edge, rise[i] <= s[i] and fall[i] <= ~s[i].
//   - Otherwise rise[i]=fall[i]=0, i.e. they are high for exactly one cycle.
//   Counter rules:
//   - The >= comparison makes lowering thresh mid-count take effect on the
//     next edge.
//   - cnt never wraps: it is cleared before it can exceed T-1 <= 2**CW-2.
//   Latency and filtering:
//   - A level first sampled by the synchroniser at edge n and held stable
//     appears on clean_out after edge n+SYNCS-1+T.
//   - Any glitch on s[i] back to clean_out[i] restarts the count. Pulses
//     shorter than T cycles (post-sync) never propagate.
//   - Channels are fully independent. Simultaneous transitions on several
//     channels each produce their own pulse on the same cycle.
//   - With T=1 the block is a pure synchroniser plus edge detector:
//     latency SYNCS cycles.
//
// TESTING
//   1. N=4, CW=8, thresh=10, en=1: step noisy_in[0] 0->1 and hold. clean_out[0]
//      rises exactly SYNCS-1+10 edges after first sample; rise[0] high for 1
//      cycle; other channels static.
//   2. Bounce noisy_in[1]: high 6 cycles, low 2, high 12. The first burst is
//      rejected; clean_out[1] rises only after the final 10 stable post-sync
//      cycles. Exactly one rise[1] pulse and no fall[1].
//   3. Assert reset at count 5 of a pending 1->0 on ch2 (RSTVAL=0, clean=1).
//      clean_out=0000, rise=fall=0 the cycle after. No pulse after reset drops
//      while input stays 0.
//   4. en=0 during a pending transition at count 4, held 20 cycles. No output
//      change. On en=1 the transition completes 6 cycles later (thresh=10).
//   5. thresh=0 and thresh=1: 1-cycle input pulse after sync toggles clean_out
//      up then down. rise then fall on consecutive cycles. any_event high in
//      both cycles.
//   6. All 4 channels step 0->1 on the same edge. All rise bits assert on one
//      cycle, rise=4'b1111. Then thresh lowered from 200 to 3 mid-count
//      (count=50) on a new edge: the flip occurs on the next edge.

Source files
------------

// File: rtl/debouncer_array.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_array
//  Description : N-channel debouncer with programmable filter length; clean
//                level plus single-cycle rise/fall pulses per channel.
//  Revision    : 1.0 - initial release
// ============================================================================

module debouncer_array #(
  parameter int           N      = 4,
  parameter int           CW     = 16,
  parameter int           SYNCS  = 2,
  parameter logic [N-1:0] RSTVAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  noisy_in,
  input  logic [CW-1:0] thresh,
  input  logic          en,
  output logic [N-1:0]  clean_out,
  output logic [N-1:0]  rise,
  output logic [N-1:0]  fall,
  output logic          any_event
);

  localparam logic [CW-1:0] c_one = CW'(1);

  logic [N-1:0]  r_sync [SYNCS];
  logic [N-1:0]  w_s;
  logic [CW-1:0] w_lim;

  // Synchroniser keeps running regardless of en so the input view stays fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNCS; k++) r_sync[k] <= RSTVAL;
    end else begin
      r_sync[0] <= noisy_in;
      for (int k = 1; k < SYNCS; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s   = r_sync[SYNCS-1];
  // Threshold of 0 behaves as 1, so the limit T-1 bottoms out at 0.
  assign w_lim = (thresh == '0) ? '0 : (thresh - c_one);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= '0;
        r_clean <= RSTVAL[i];
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (en) begin
          if (w_s[i] == r_clean) begin
            r_cnt <= '0;
          end else if (r_cnt >= w_lim) begin
            r_clean <= w_s[i];
            r_cnt   <= '0;
            r_rise  <= w_s[i];
            r_fall  <= ~w_s[i];
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
      end
    end

    assign clean_out[i] = r_clean;
    assign rise[i]      = r_rise;
    assign fall[i]      = r_fall;
  end

  assign any_event = |(rise | fall);

endmodule

`default_nettype wire

// File: tb/tb_debouncer_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer_array
//  Description : Scoreboard bench for debouncer_array (N=4, CW=8, SYNCS=2).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_debouncer_array;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  noisy_in;
  logic [CW-1:0] thresh;
  logic          en;
  logic [N-1:0]  clean_out;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic          any_event;

  debouncer_array #(
    .N      (N),
    .CW     (CW),
    .SYNCS  (2),
    .RSTVAL (4'b0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .noisy_in  (noisy_in),
    .thresh    (thresh),
    .en        (en),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall),
    .any_event (any_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] clean;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic [N-1:0] r, input logic [N-1:0] f,
                           input logic [N-1:0] c);
    exp_t e;
    e.at = at; e.rise = r; e.fall = f; e.clean = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every event cycle must match the next queued expectation exactly.
  always @(negedge clk) begin
    if (reset === 1'b0 && any_event === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: rise=%b fall=%b clean=%b at cycle %0d, none expected",
                 rise, fall, clean_out, cyc);
      end else begin
        e_mon = exp_q.pop_front();
        if (cyc == e_mon.at && rise === e_mon.rise && fall === e_mon.fall &&
            clean_out === e_mon.clean)
          passed++;
        else
          $display("FAIL event: got cyc=%0d rise=%b fall=%b clean=%b expected cyc=%0d rise=%b fall=%b clean=%b",
                   cyc, rise, fall, clean_out, e_mon.at, e_mon.rise, e_mon.fall, e_mon.clean);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; noisy_in = '0; thresh = 8'd10; en = 1'b1;
    tick(3);
    chk("reset_clean", 32'(clean_out), 32'h0);
    chk("reset_rise",  32'(rise),      32'h0);
    chk("reset_fall",  32'(fall),      32'h0);
    reset = 1'b0;
    tick(3);

    // 1: single step on ch0, latency = SYNCS-1+T after first sample
    k = cyc;
    expect_ev(k + 12, 4'b0001, 4'b0000, 4'b0001);
    noisy_in[0] = 1'b1;
    tick(20);
    chk("t1_clean", 32'(clean_out), 32'h1);

    // 2: bounce on ch1 - 6 high, 2 low, then held high
    k = cyc;
    noisy_in[1] = 1'b1;
    tick(6);
    noisy_in[1] = 1'b0;
    tick(2);
    chk("t2_burst_rejected", 32'(clean_out), 32'h1);
    expect_ev(k + 20, 4'b0010, 4'b0000, 4'b0011);
    noisy_in[1] = 1'b1;
    tick(16);
    chk("t2_clean", 32'(clean_out), 32'h3);

    // 3: reset at count 5 of a pending 1->0 on ch2
    k = cyc;
    expect_ev(k + 12, 4'b0100, 4'b0000, 4'b0111);
    noisy_in[2] = 1'b1;
    tick(15);
    k = cyc;
    noisy_in[2] = 1'b0;
    tick(7);
    reset = 1'b1;
    tick(1);
    chk("t3_reset_clean", 32'(clean_out), 32'h0);
    chk("t3_reset_rise",  32'(rise),      32'h0);
    chk("t3_reset_fall",  32'(fall),      32'h0);
    // ch0/ch1 inputs are still high, so they re-qualify after a full filter
    expect_ev(cyc + 12, 4'b0011, 4'b0000, 4'b0011);
    reset = 1'b0;
    tick(20);
    chk("t3_after", 32'(clean_out), 32'h3);

    // 4: en dropped at count 4 on ch3 for 20 cycles
    k = cyc;
    expect_ev(k + 32, 4'b1000, 4'b0000, 4'b1011);
    noisy_in[3] = 1'b1;
    tick(6);
    en = 1'b0;
    tick(10);
    chk("t4_frozen", 32'(clean_out), 32'h3);
    tick(10);
    en = 1'b1;
    tick(10);
    chk("t4_clean", 32'(clean_out), 32'hB);

    // 5: 1-cycle pulse with thresh=0 then thresh=1
    for (int t = 0; t < 2; t++) begin
      thresh = 8'(t);
      k = cyc;
      expect_ev(k + 3, 4'b0100, 4'b0000, 4'b1111);
      expect_ev(k + 4, 4'b0000, 4'b0100, 4'b1011);
      noisy_in[2] = 1'b1;
      tick(1);
      noisy_in[2] = 1'b0;
      tick(8);
    end

    // 6: simultaneous channels, then thresh lowered mid-count
    k = cyc;
    expect_ev(k + 3, 4'b0000, 4'b1011, 4'b0000);
    noisy_in = 4'b0000;
    tick(6);
    thresh = 8'd10;
    k = cyc;
    expect_ev(k + 12, 4'b1111, 4'b0000, 4'b1111);
    noisy_in = 4'b1111;
    tick(15);
    thresh = 8'd200;
    k = cyc;
    noisy_in[0] = 1'b0;
    tick(52);
    expect_ev(k + 53, 4'b0000, 4'b0001, 4'b1110);
    thresh = 8'd3;
    tick(6);
    chk("t6_clean", 32'(clean_out), 32'hE);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
